tq_row_packer: RTL and testbench
================================

// Module: tq_row_packer
// PURPOSE
//   Input row assembler for the forward/inverse transform pipeline. Accepts residual
//   (or coefficient) samples LANES per beat, collects one transform row of N = 4/8/16/32
//   samples, then presents it as 32 parallel lanes with a one-cycle valid to the first
//   butterfly/permute stage. Tracks row/block position; flags framing errors.
// PARAMETERS
//   LANES  4   samples per input beat (fixed 4; beats/row = N/4)
//   DW     16  sample width, signed two's complement
// PORTS
//   clk          in   1        clock
//   rst          in   1        async reset, active-low
//   i_valid      in   1        input beat valid
//   o_ready      out  1        packer accepts beats (beat taken when i_valid&o_ready)
//   i_sof        in   1        beat is first beat of a new block
//   i_transize   in   2        0=4x4 1=8x8 2=16x16 3=32x32; sampled only on i_sof beat
//   i_inverse    in   1        transform direction; sampled only on i_sof beat
//   i_data       in   LANES*DW lane k at [16k+15:16k] = row sample beat*4+k
//   o_valid      out  1        row complete, o_0..o_31 valid this cycle
//   o_transize   out  2        latched block size for this row
//   o_inverse    out  1        latched direction for this row
//   o_0..o_31    out  DW each  row samples, sample j on o_j (signed)
//   o_eob        out  1        with o_valid: last row (row N-1) of block
//   o_err        out  1        one-cycle framing-error pulse
// BEHAVIOUR
//   Reset: o_ready=0, o_valid=0, o_eob=0, o_err=0, o_transize=0, o_inverse=0, o_0..o_31=0,
//     beat_cnt=0, row_cnt=0, state=IDLE. o_ready goes 1 on first clk edge after rst release,
//     stays 1 (no downstream backpressure; output reg is separate from assembly reg).
//   FSM: IDLE -> ACTIVE on accepted beat with i_sof. ACTIVE -> IDLE after last beat of row N-1.
//   IDLE, accepted beat without i_sof: beat dropped, o_err=1 next cycle, stay IDLE.
//   ACTIVE, accepted beat: lanes written to assembly slots beat_cnt*4..+3; beat_cnt++.
//   Last beat of row (beat_cnt==N/4-1): next cycle o_valid=1, o_0..o_31 = assembled row,
//     o_eob=(row_cnt==N-1); beat_cnt<=0, row_cnt++ (wraps to 0 at block end). Latency 1 cycle.
//   i_valid gaps allowed anywhere; counters hold, o_valid stays 0.
//   i_sof while ACTIVE and (beat_cnt!=0 or row_cnt!=0): partial row/block discarded, o_err=1
//     next cycle, this beat starts a new block (new transize/inverse latched).
//   i_sof at an exact block boundary (row_cnt==0, beat_cnt==0, ACTIVE) is legal, no error.
//   Back-to-back blocks: last beat of block and sof beat on consecutive cycles -> no bubble.
//   N=4: every beat completes a row (o_valid may be high every cycle).
//   o_transize/o_inverse/o_eob update only with o_valid; o_0..o_31 hold between rows.
//   o_valid, o_eob, o_err are single-cycle pulses. Reset mid-block: everything cleared,
//     partial row lost, no o_valid/o_err emitted.
// CONFIGURATION
//   TQ_PACKER_ZERO_PAD_EN defined: lanes j>=N forced to 0 in every output row.
//   Not defined: lanes j>=N hold last values written (stale from earlier larger blocks);
//     downstream must ignore them per o_transize.
// TESTING
//   4x4: sof beat, transize=0, 4 beats data {3,2,1,0}+4r -> 4 o_valid pulses, o_j=4r+j, eob on r=3.
//   32x32: sof, 8 beats samples 0..31, gaps of 2 cycles between beats -> o_valid once, o_j=j,
//     o_eob=0, o_transize=3; after 32 rows o_eob=1, state IDLE.
//   Framing: 8x8 block, sof asserted on beat 1 of row 3 -> o_err pulse, no o_valid for row 3,
//     new block rows counted from 0.
//   Idle beat without sof (data 0x7FFF) -> o_err pulse, no o_valid, state stays IDLE.
//   Reset mid-row of 16x16 block -> all outputs 0; following sof block outputs correct rows.
//   Pad: 32x32 row of -1, then 4x4 row of 5 -> o_0..o_3=5; o_4..o_31=0 with
//     TQ_PACKER_ZERO_PAD_EN, =-1 (0xFFFF) without.

Source files
------------

// File: rtl/tq_row_packer.sv
// tq_row_packer: gathers 4-sample beats into one 32-lane transform row.
// Build option TQ_PACKER_ZERO_PAD_EN zeroes output lanes beyond N.

module tq_row_packer #(
  parameter int LANES = 4,
  parameter int DW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sof,
  input  logic [1:0]            i_transize,
  input  logic                  i_inverse,
  input  logic [LANES*DW-1:0]   i_data,
  output logic                  o_valid,
  output logic [1:0]            o_transize,
  output logic                  o_inverse,
  output logic signed [DW-1:0]  o_0,
  output logic signed [DW-1:0]  o_1,
  output logic signed [DW-1:0]  o_2,
  output logic signed [DW-1:0]  o_3,
  output logic signed [DW-1:0]  o_4,
  output logic signed [DW-1:0]  o_5,
  output logic signed [DW-1:0]  o_6,
  output logic signed [DW-1:0]  o_7,
  output logic signed [DW-1:0]  o_8,
  output logic signed [DW-1:0]  o_9,
  output logic signed [DW-1:0]  o_10,
  output logic signed [DW-1:0]  o_11,
  output logic signed [DW-1:0]  o_12,
  output logic signed [DW-1:0]  o_13,
  output logic signed [DW-1:0]  o_14,
  output logic signed [DW-1:0]  o_15,
  output logic signed [DW-1:0]  o_16,
  output logic signed [DW-1:0]  o_17,
  output logic signed [DW-1:0]  o_18,
  output logic signed [DW-1:0]  o_19,
  output logic signed [DW-1:0]  o_20,
  output logic signed [DW-1:0]  o_21,
  output logic signed [DW-1:0]  o_22,
  output logic signed [DW-1:0]  o_23,
  output logic signed [DW-1:0]  o_24,
  output logic signed [DW-1:0]  o_25,
  output logic signed [DW-1:0]  o_26,
  output logic signed [DW-1:0]  o_27,
  output logic signed [DW-1:0]  o_28,
  output logic signed [DW-1:0]  o_29,
  output logic signed [DW-1:0]  o_30,
  output logic signed [DW-1:0]  o_31,
  output logic                  o_eob,
  output logic                  o_err
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [2:0] beat_q;
  logic [4:0] row_q;
  logic [1:0] size_q;
  logic       inv_q;

  logic signed [DW-1:0] asm_q [32];
  logic signed [DW-1:0] out_q [32];
  logic signed [DW-1:0] row_m [32];
  logic signed [DW-1:0] row_o [32];

  logic       take;
  logic       wr;
  logic       drop;
  logic       frame_err;
  logic       row_done;
  logic       blk_done;
  logic [1:0] eff_size;
  logic       eff_inv;
  logic [2:0] eff_beat;
  logic [4:0] eff_row;
  logic [2:0] last_beat;
  logic [4:0] last_row;

  assign take = i_valid & o_ready;

  // A sof beat always restarts at row 0 / beat 0 with its own size.
  assign eff_size = i_sof ? i_transize : size_q;
  assign eff_inv  = i_sof ? i_inverse : inv_q;
  assign eff_beat = i_sof ? 3'd0 : beat_q;
  assign eff_row  = i_sof ? 5'd0 : row_q;

  always_comb begin
    last_beat = 3'd0;
    last_row  = 5'd3;
    unique case (eff_size)
      2'd0: begin last_beat = 3'd0; last_row = 5'd3;  end
      2'd1: begin last_beat = 3'd1; last_row = 5'd7;  end
      2'd2: begin last_beat = 3'd3; last_row = 5'd15; end
      2'd3: begin last_beat = 3'd7; last_row = 5'd31; end
    endcase
  end

  assign drop      = take & ~i_sof & (state_q == IDLE);
  assign wr        = take & (i_sof | (state_q == ACTIVE));
  assign frame_err = take & i_sof & (state_q == ACTIVE)
                   & ((beat_q != 3'd0) | (row_q != 5'd0));
  assign row_done  = wr & (eff_beat == last_beat);
  assign blk_done  = row_done & (eff_row == last_row);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (wr) state_d = blk_done ? IDLE : ACTIVE;
      ACTIVE: if (blk_done) state_d = IDLE;
    endcase
  end

  always_comb begin
    row_m = asm_q;
    for (int k = 0; k < LANES; k++) begin
      row_m[{eff_beat, k[1:0]}] = i_data[k*DW +: DW];
    end
  end

`ifdef TQ_PACKER_ZERO_PAD_EN
  logic [5:0] n_eff;

  assign n_eff = 6'd4 << eff_size;

  always_comb begin
    row_o = row_m;
    for (int j = 0; j < 32; j++) begin
      if (j >= int'(n_eff)) row_o[j] = '0;
    end
  end
`else
  // Lanes past N keep whatever the assembly buffer last held.
  always_comb begin
    row_o = row_m;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_ready    <= 1'b0;
      o_valid    <= 1'b0;
      o_eob      <= 1'b0;
      o_err      <= 1'b0;
      o_transize <= 2'd0;
      o_inverse  <= 1'b0;
      beat_q     <= 3'd0;
      row_q      <= 5'd0;
      size_q     <= 2'd0;
      inv_q      <= 1'b0;
      asm_q      <= '{default: '0};
      out_q      <= '{default: '0};
    end else begin
      o_ready <= 1'b1;
      o_valid <= row_done;
      o_eob   <= blk_done;
      o_err   <= frame_err | drop;
      if (take & i_sof) begin
        size_q <= i_transize;
        inv_q  <= i_inverse;
      end
      if (wr) asm_q <= row_m;
      if (row_done) begin
        out_q      <= row_o;
        o_transize <= eff_size;
        o_inverse  <= eff_inv;
        beat_q     <= 3'd0;
        row_q      <= blk_done ? 5'd0 : eff_row + 5'd1;
      end else if (wr) begin
        beat_q <= eff_beat + 3'd1;
        row_q  <= eff_row;
      end
    end
  end

  assign o_0  = out_q[0];
  assign o_1  = out_q[1];
  assign o_2  = out_q[2];
  assign o_3  = out_q[3];
  assign o_4  = out_q[4];
  assign o_5  = out_q[5];
  assign o_6  = out_q[6];
  assign o_7  = out_q[7];
  assign o_8  = out_q[8];
  assign o_9  = out_q[9];
  assign o_10 = out_q[10];
  assign o_11 = out_q[11];
  assign o_12 = out_q[12];
  assign o_13 = out_q[13];
  assign o_14 = out_q[14];
  assign o_15 = out_q[15];
  assign o_16 = out_q[16];
  assign o_17 = out_q[17];
  assign o_18 = out_q[18];
  assign o_19 = out_q[19];
  assign o_20 = out_q[20];
  assign o_21 = out_q[21];
  assign o_22 = out_q[22];
  assign o_23 = out_q[23];
  assign o_24 = out_q[24];
  assign o_25 = out_q[25];
  assign o_26 = out_q[26];
  assign o_27 = out_q[27];
  assign o_28 = out_q[28];
  assign o_29 = out_q[29];
  assign o_30 = out_q[30];
  assign o_31 = out_q[31];

endmodule

// File: tb/tb_tq_row_packer.sv
// tb_tq_row_packer: directed and random checks of tq_row_packer
// against a queue-based row model.

module tb_tq_row_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sof;
  logic [1:0]  i_transize;
  logic        i_inverse;
  logic [63:0] i_data;
  logic        o_valid;
  logic [1:0]  o_transize;
  logic        o_inverse;
  logic        o_eob;
  logic        o_err;
  logic [15:0] o_lane [32];

  int checks = 0;
  int errors = 0;

`ifdef TQ_PACKER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  always #5 clk = ~clk;

  tq_row_packer dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sof(i_sof), .i_transize(i_transize), .i_inverse(i_inverse),
    .i_data(i_data), .o_valid(o_valid), .o_transize(o_transize),
    .o_inverse(o_inverse),
    .o_0(o_lane[0]),   .o_1(o_lane[1]),   .o_2(o_lane[2]),
    .o_3(o_lane[3]),   .o_4(o_lane[4]),   .o_5(o_lane[5]),
    .o_6(o_lane[6]),   .o_7(o_lane[7]),   .o_8(o_lane[8]),
    .o_9(o_lane[9]),   .o_10(o_lane[10]), .o_11(o_lane[11]),
    .o_12(o_lane[12]), .o_13(o_lane[13]), .o_14(o_lane[14]),
    .o_15(o_lane[15]), .o_16(o_lane[16]), .o_17(o_lane[17]),
    .o_18(o_lane[18]), .o_19(o_lane[19]), .o_20(o_lane[20]),
    .o_21(o_lane[21]), .o_22(o_lane[22]), .o_23(o_lane[23]),
    .o_24(o_lane[24]), .o_25(o_lane[25]), .o_26(o_lane[26]),
    .o_27(o_lane[27]), .o_28(o_lane[28]), .o_29(o_lane[29]),
    .o_30(o_lane[30]), .o_31(o_lane[31]),
    .o_eob(o_eob), .o_err(o_err)
  );

  // Reference model: samples of the open row in a queue,
  // plus the last value ever written to each of the 32 slots.
  bit          m_active;
  int          m_n;
  int          m_row;
  logic [1:0]  m_ts;
  bit          m_inv;
  int          q[$];
  logic [15:0] m_lane [32];
  bit          e_valid, e_err, e_eob, e_inv;
  logic [1:0]  e_ts;
  logic [15:0] e_row [32];

  function automatic logic [63:0] seq(input int base);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = 16'(base + k);
    return r;
  endfunction

  task automatic mreset();
    m_active = 0; m_row = 0; m_n = 4; m_ts = 0; m_inv = 0;
    q.delete();
    e_valid = 0; e_err = 0; e_eob = 0; e_inv = 0; e_ts = 0;
    for (int j = 0; j < 32; j++) begin
      m_lane[j] = '0;
      e_row[j]  = '0;
    end
  endtask

  task automatic step(input bit v, input bit sof, input logic [1:0] ts,
                      input bit inv, input logic [63:0] data);
    bit wr;
    @(negedge clk);
    i_valid = v; i_sof = sof; i_transize = ts;
    i_inverse = inv; i_data = data;
    @(posedge clk);
    #1;
    e_valid = 0; e_err = 0; e_eob = 0; wr = 0;
    if (v) begin
      wr = 1;
      if (sof) begin
        if (m_active && (q.size() != 0 || m_row != 0)) e_err = 1;
        m_active = 1; m_n = 4 << ts; m_ts = ts; m_inv = inv;
        m_row = 0; q.delete();
      end else if (!m_active) begin
        e_err = 1; wr = 0;
      end
    end
    if (wr) begin
      for (int k = 0; k < 4; k++) begin
        m_lane[q.size()] = data[16*k +: 16];
        q.push_back(int'(data[16*k +: 16]));
      end
      if (q.size() == m_n) begin
        e_valid = 1; e_eob = (m_row == m_n - 1);
        e_ts = m_ts; e_inv = m_inv;
        for (int j = 0; j < 32; j++)
          e_row[j] = (j < m_n) ? 16'(q[j]) : (PAD ? 16'h0 : m_lane[j]);
        q.delete();
        if (e_eob) begin
          m_active = 0; m_row = 0;
        end else m_row++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 0; i_valid = 0; i_sof = 0; i_transize = 0;
    i_inverse = 0; i_data = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 0 || o_valid !== 0 || o_err !== 0 || o_eob !== 0
        || o_transize !== 0 || o_inverse !== 0 || o_lane[7] !== 0) begin
      errors++;
      $display("FAIL reset_outs got rdy=%b v=%b err=%b eob=%b ts=%0d inv=%b l7=%h want all 0",
               o_ready, o_valid, o_err, o_eob, o_transize, o_inverse, o_lane[7]);
    end
    @(negedge clk);
    rst = 1;
    step(0, 0, 0, 0, '0);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", o_ready);
    end
  endtask

  task automatic test_idle_beat();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, {4{16'h7FFF}});
      checks++;
      if (o_err !== 1'b1 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_drop%0d got err=%b v=%b want err=1 v=0", i, o_err, o_valid);
      end
      step(0, 0, 0, 0, '0);
      checks++;
      if (o_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_pulse%0d got err=%b want 0", i, o_err);
      end
    end
  endtask

  task automatic test_4x4();
    for (int r = 0; r < 4; r++) begin
      step(1, r == 0, 2'd0, 1'b1, seq(4 * r));
      checks++;
      if (o_valid !== 1'b1 || o_eob !== (r == 3) || o_err !== 1'b0) begin
        errors++;
        $display("FAIL 4x4_flags r=%0d got v=%b eob=%b err=%b want v=1 eob=%b err=0",
                 r, o_valid, o_eob, o_err, r == 3);
      end
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (o_lane[j] !== 16'(4 * r + j)) begin
          errors++;
          $display("FAIL 4x4_lane r=%0d j=%0d got %h want %h", r, j, o_lane[j], 16'(4*r+j));
        end
      end
    end
    checks++;
    if (o_transize !== 2'd0 || o_inverse !== 1'b1) begin
      errors++;
      $display("FAIL 4x4_attr got ts=%0d inv=%b want ts=0 inv=1", o_transize, o_inverse);
    end
  endtask

  task automatic test_32x32_gaps();
    for (int r = 0; r < 32; r++) begin
      for (int b = 0; b < 8; b++) begin
        step(1, r == 0 && b == 0, 2'd3, 1'b0, seq(32 * r + 4 * b));
        checks++;
        if (o_valid !== (b == 7) || o_err !== 1'b0) begin
          errors++;
          $display("FAIL 32_valid r=%0d b=%0d got v=%b err=%b want v=%b err=0",
                   r, b, o_valid, o_err, b == 7);
        end
        if (b == 7) begin
          checks++;
          if (o_eob !== (r == 31) || o_transize !== 2'd3 || o_inverse !== 1'b0) begin
            errors++;
            $display("FAIL 32_attr r=%0d got eob=%b ts=%0d inv=%b want eob=%b ts=3 inv=0",
                     r, o_eob, o_transize, o_inverse, r == 31);
          end
          for (int j = 0; j < 32; j++) begin
            checks++;
            if (o_lane[j] !== 16'(32 * r + j)) begin
              errors++;
              $display("FAIL 32_lane r=%0d j=%0d got %h want %h", r, j, o_lane[j], 16'(32*r+j));
            end
          end
        end
        repeat (2) begin
          step(0, 0, 0, 0, '0);
          checks++;
          if (o_valid !== 1'b0 || o_eob !== 1'b0) begin
            errors++;
            $display("FAIL 32_gap r=%0d b=%0d got v=%b eob=%b want 0", r, b, o_valid, o_eob);
          end
        end
      end
    end
    step(1, 0, 0, 0, seq(1));
    checks++;
    if (o_err !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL 32_idle_after got err=%b v=%b want err=1 v=0", o_err, o_valid);
    end
  endtask

  task automatic test_framing();
    for (int i = 0; i < 7; i++) begin
      step(1, i == 0, 2'd1, 1'b0, seq(1000 + 4 * i));
      checks++;
      if (o_valid !== (i % 2 == 1) || o_err !== 1'b0) begin
        errors++;
        $display("FAIL frm_pre i=%0d got v=%b err=%b want v=%b err=0",
                 i, o_valid, o_err, i % 2 == 1);
      end
    end
    step(1, 1, 2'd1, 1'b1, seq(0));
    checks++;
    if (o_err !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL frm_err got err=%b v=%b want err=1 v=0", o_err, o_valid);
    end
    for (int i = 1; i < 16; i++) begin
      step(1, 0, 2'd0, 1'b0, seq(4 * i));
      checks++;
      if (o_valid !== (i % 2 == 1) || o_err !== 1'b0
          || o_eob !== (i == 15)) begin
        errors++;
        $display("FAIL frm_new i=%0d got v=%b err=%b eob=%b want v=%b err=0 eob=%b",
                 i, o_valid, o_err, o_eob, i % 2 == 1, i == 15);
      end
      if (i % 2 == 1) begin
        checks++;
        if (o_lane[0] !== 16'(4 * i - 4) || o_lane[7] !== 16'(4 * i + 3)
            || o_inverse !== 1'b1 || o_transize !== 2'd1) begin
          errors++;
          $display("FAIL frm_row i=%0d got l0=%h l7=%h inv=%b ts=%0d want %h %h 1 1",
                   i, o_lane[0], o_lane[7], o_inverse, o_transize,
                   16'(4*i-4), 16'(4*i+3));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 2'd2, 1'b1, seq(77));
    step(1, 0, 2'd2, 1'b1, seq(81));
    @(negedge clk);
    i_valid = 0;
    rst = 0;
    #1;
    mreset();
    checks++;
    if (o_ready !== 0 || o_valid !== 0 || o_err !== 0 || o_eob !== 0
        || o_transize !== 0 || o_inverse !== 0 || o_lane[0] !== 0
        || o_lane[31] !== 0) begin
      errors++;
      $display("FAIL rstmid_outs got rdy=%b v=%b err=%b ts=%0d l0=%h l31=%h want 0",
               o_ready, o_valid, o_err, o_transize, o_lane[0], o_lane[31]);
    end
    #2 rst = 1;
    step(0, 0, 0, 0, '0);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release got rdy=%b v=%b err=%b want 1 0 0", o_ready, o_valid, o_err);
    end
    for (int r = 0; r < 16; r++) begin
      for (int b = 0; b < 4; b++) begin
        step(1, r == 0 && b == 0, 2'd2, 1'b0, seq(16 * r + 4 * b + 500));
        checks++;
        if (o_valid !== (b == 3) || o_err !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_valid r=%0d b=%0d got v=%b err=%b want v=%b err=0",
                   r, b, o_valid, o_err, b == 3);
        end
      end
      checks++;
      if (o_lane[0] !== 16'(16 * r + 500) || o_lane[15] !== 16'(16 * r + 515)
          || o_eob !== (r == 15) || o_transize !== 2'd2) begin
        errors++;
        $display("FAIL rstmid_row r=%0d got l0=%h l15=%h eob=%b ts=%0d want %h %h %b 2",
                 r, o_lane[0], o_lane[15], o_eob, o_transize,
                 16'(16*r+500), 16'(16*r+515), r == 15);
      end
    end
  endtask

  task automatic test_pad();
    logic [15:0] want;
    want = PAD ? 16'h0000 : 16'hFFFF;
    for (int b = 0; b < 8; b++) step(1, b == 0, 2'd3, 1'b0, {4{16'hFFFF}});
    step(1, 1, 2'd0, 1'b0, {4{16'h0005}});
    checks++;
    if (o_valid !== 1'b1 || o_err !== 1'b1 || o_transize !== 2'd0) begin
      errors++;
      $display("FAIL pad_flags got v=%b err=%b ts=%0d want 1 1 0", o_valid, o_err, o_transize);
    end
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (o_lane[j] !== ((j < 4) ? 16'h0005 : want)) begin
        errors++;
        $display("FAIL pad_lane j=%0d got %h want %h", j, o_lane[j],
                 (j < 4) ? 16'h0005 : want);
      end
    end
    for (int r = 1; r < 4; r++) step(1, 0, 2'd0, 1'b0, {4{16'h0005}});
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int i = 0; i < 16 + 4 + 4; i++) begin
      if (i < 16) step(1, i == 0, 2'd1, 1'b1, seq(300 + 4 * i));
      else if (i < 20) step(1, i == 16, 2'd0, 1'b0, seq(600 + 4 * i));
      else step(1, i == 20, 2'd2, 1'b1, seq(900 + 4 * i));
      checks++;
      if (o_valid !== e_valid || o_err !== 1'b0 || o_eob !== e_eob) begin
        errors++;
        $display("FAIL b2b_flags i=%0d got v=%b err=%b eob=%b want v=%b err=0 eob=%b",
                 i, o_valid, o_err, o_eob, e_valid, e_eob);
      end
      bad = -1;
      for (int j = 0; j < 32; j++) if (o_lane[j] !== e_row[j]) bad = j;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL b2b_lane i=%0d j=%0d got %h want %h", i, bad, o_lane[bad], e_row[bad]);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    bit v, sof;
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (!m_active) sof = ($urandom_range(0, 4) != 0);
      else sof = ($urandom_range(0, 39) == 0);
      step(v, sof, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom});
      checks++;
      if (o_valid !== e_valid || o_err !== e_err || o_eob !== e_eob) begin
        errors++;
        $display("FAIL rnd_flags i=%0d got v=%b err=%b eob=%b want v=%b err=%b eob=%b",
                 i, o_valid, o_err, o_eob, e_valid, e_err, e_eob);
      end
      checks++;
      if (o_transize !== e_ts || o_inverse !== e_inv) begin
        errors++;
        $display("FAIL rnd_attr i=%0d got ts=%0d inv=%b want ts=%0d inv=%b",
                 i, o_transize, o_inverse, e_ts, e_inv);
      end
      bad = -1;
      for (int j = 0; j < 32; j++) if (o_lane[j] !== e_row[j]) bad = j;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL rnd_lane i=%0d j=%0d got %h want %h", i, bad, o_lane[bad], e_row[bad]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_beat();
    test_4x4();
    test_32x32_gaps();
    test_framing();
    test_reset_mid();
    test_pad();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
